nasti_ram_slave: RTL and testbench
==================================

Name: nasti_ram_slave

Overview:
- NASTI responder (slave end) that terminates all five NASTI channels on an internal synchronous single-port RAM.
- Accepts AW/W and returns B; accepts AR and returns R bursts.
- Sits at the far end of a NASTI crossbar or port as a scratchpad / boot RAM and as the reference target for initiator benches.
- Serves one transaction at a time; round-robin between read and write requests.

Parameters:
ID_WIDTH, 1, transaction ID width on aw/b/ar/r
ADDR_WIDTH, 16, byte address width
DATA_WIDTH, 64, data bus width in bits (power of two, >= 8)
USER_WIDTH, 1, user field width on all channels
MEM_DEPTH, 1024, RAM depth in DATA_WIDTH words

Ports:
clk  input  1  clock; all logic on rising edge
rstn  input  1  asynchronous active-low reset
aw  nasti_aw (slave end)  ID/ADDR/USER_WIDTH  write address channel; drives ready, samples the rest
w  nasti_w (slave end)  DATA/USER_WIDTH  write data channel; drives ready
b  nasti_b (slave end)  ID/USER_WIDTH  write response channel; drives id, resp, user, valid
ar  nasti_ar (slave end)  ID/ADDR/USER_WIDTH  read address channel; drives ready
r  nasti_r (slave end)  ID/DATA/USER_WIDTH  read data channel; drives id, data, resp, last, user, valid

Behaviour:
- Reset (rstn low, asynchronous):
  - State goes to IDLE; priority goes to WRITE.
  - All valid and ready outputs are 0 while rstn is low.
  - id, resp, data, last and user outputs are 0.
  - RAM contents are not reset.
- Reset mid-burst aborts the burst with no response; the RAM keeps any beats already written.
- FSM states: IDLE, WRITE, WRESP, RADDR, RDATA.
- IDLE:
  - aw.ready = aw.valid allowed and (not ar.valid or prio == WRITE).
  - ar.ready = ar.valid allowed and (not aw.valid or prio == READ).
  - Readies are combinational from state/prio/valids and are never high outside IDLE.
  - An AW handshake latches id, addr, len, size and burst, goes to WRITE and sets prio = READ.
  - An AR handshake latches the same fields, goes to RADDR and sets prio = WRITE.
  - Only one grant can occur per cycle.
- Address arithmetic:
  - Word index = (addr >> log2(DATA_WIDTH/8)) mod MEM_DEPTH.
  - INCR: addr += 2^size bytes per beat; the next word is touched only when the increment crosses a word.
  - FIXED: addr constant for the whole burst.
  - WRAP: unsupported; all beats are still transferred, writes are dropped, read data is 0, resp = SLVERR (2).
- Beat counter is loaded with len and the burst has len+1 beats. len = 0 gives a single beat.
- WRITE:
  - w.ready = 1.
  - Each handshake writes the bytes whose strb bit is set.
  - The burst ends when the counter reaches 0, then the state goes to WRESP.
  - If w.last is 0 on the final beat, or 1 on an earlier beat, the burst is still counted by len and the response becomes SLVERR.
- WRESP:
  - b.valid = 1 from the cycle after the final W handshake; b.id = latched id; resp = OKAY (0) unless an error was flagged; b.user = 0.
  - Hold until b.ready, then go to IDLE.
- RADDR: issue the RAM read for the current beat; go to RDATA next cycle.
- RDATA:
  - r.valid = 1 with registered RAM data; r.id = latched id; r.last = 1 only on the final beat; r.user = 0.
  - data, last and resp are held stable while r.ready is low.
  - On handshake: go to RADDR if beats remain, else IDLE.
  - Latency: the first r.valid comes 2 cycles after the AR handshake; peak throughput is 1 beat per 2 cycles.
- There is no write/read hazard because transactions are serialized.

Optional Feature:
- NASTI_RAM_SLAVE_DECERR_EN defined:
  - A burst whose start word index is >= MEM_DEPTH (before the modulo) returns DECERR (3) on B or on every R beat.
  - Its writes are suppressed and its read data is 0; the full beat count is still honoured.
- Undefined: addresses alias modulo MEM_DEPTH and such bursts return OKAY.

Test Plan:
- Single write: addr 0x10, len 0, size 3, strb 0xFF, data 0x1122334455667788 -> B OKAY with matching id 1 cycle after the W handshake; a read of 0x10 returns the same data, last = 1.
- INCR burst: write len 3 at 0x40, data 0..3 -> read len 3 at 0x40 returns 0,1,2,3, last only on beat 3.
- Strobe: write 0xFFFF_FFFF_FFFF_FFFF, then strb 0x0F with data 0 at the same address -> read returns 0xFFFF_FFFF_0000_0000.
- Arbitration and backpressure:
  - aw.valid and ar.valid rise together after reset -> write is granted first, then the read.
  - With r.ready low 5 cycles, r.data and r.last are held.
- Errors:
  - WRAP read len 1 -> 2 beats of 0 with resp 2.
  - Early w.last on beat 0 of len 1 -> B resp 2.
  - Macro on, addr = MEM_DEPTH*8 -> resp 3.
- Reset mid-read burst (beat 1 of 4) -> all valid/ready drop to 0 immediately; the next AR after reset completes normally.

Source files
------------

// File: rtl/nasti_ram_slave_if.sv
// NASTI channel interfaces used by nasti_ram_slave: one interface per channel,
// each with master/slave modports.

interface nasti_aw_if #(parameter int ID_WIDTH = 1, parameter int ADDR_WIDTH = 16, parameter int USER_WIDTH = 1);
  logic [ID_WIDTH-1:0]   id;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            len;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic [USER_WIDTH-1:0] user;
  logic                  valid;
  logic                  ready;
  modport master (output id, addr, len, size, burst, user, valid, input ready);
  modport slave  (input id, addr, len, size, burst, user, valid, output ready);
endinterface

interface nasti_ar_if #(parameter int ID_WIDTH = 1, parameter int ADDR_WIDTH = 16, parameter int USER_WIDTH = 1);
  logic [ID_WIDTH-1:0]   id;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            len;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic [USER_WIDTH-1:0] user;
  logic                  valid;
  logic                  ready;
  modport master (output id, addr, len, size, burst, user, valid, input ready);
  modport slave  (input id, addr, len, size, burst, user, valid, output ready);
endinterface

interface nasti_w_if #(parameter int DATA_WIDTH = 64, parameter int USER_WIDTH = 1);
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;
  logic                    last;
  logic [USER_WIDTH-1:0]   user;
  logic                    valid;
  logic                    ready;
  modport master (output data, strb, last, user, valid, input ready);
  modport slave  (input data, strb, last, user, valid, output ready);
endinterface

interface nasti_b_if #(parameter int ID_WIDTH = 1, parameter int USER_WIDTH = 1);
  logic [ID_WIDTH-1:0]   id;
  logic [1:0]            resp;
  logic [USER_WIDTH-1:0] user;
  logic                  valid;
  logic                  ready;
  modport master (input id, resp, user, valid, output ready);
  modport slave  (output id, resp, user, valid, input ready);
endinterface

interface nasti_r_if #(parameter int ID_WIDTH = 1, parameter int DATA_WIDTH = 64, parameter int USER_WIDTH = 1);
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [1:0]            resp;
  logic                  last;
  logic [USER_WIDTH-1:0] user;
  logic                  valid;
  logic                  ready;
  modport master (input id, data, resp, last, user, valid, output ready);
  modport slave  (output id, data, resp, last, user, valid, input ready);
endinterface

// File: rtl/nasti_ram_slave.sv
// NASTI slave terminating AW/W/B/AR/R on a byte-laned single-port RAM, one transaction at a time.
// Define NASTI_RAM_SLAVE_DECERR_EN to answer bursts starting past MEM_DEPTH with DECERR.

module nasti_ram_slave_lane #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

module nasti_ram_slave #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic      clk,
  input  logic      rstn,
  nasti_aw_if.slave aw,
  nasti_w_if.slave  w,
  nasti_b_if.slave  b,
  nasti_ar_if.slave ar,
  nasti_r_if.slave  r
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int MW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0] OKAY = 2'd0, SLVERR = 2'd2, DECERR = 2'd3;
  localparam logic [1:0] INCR = 2'd1;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;
  typedef enum logic {P_WRITE, P_READ} prio_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            cnt;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [1:0]            resp;
    logic                  drop;
  } xact_t;

  state_t             state, state_n;
  prio_t              prio, prio_n;
  xact_t              xq;
  logic               aw_hs, ar_hs, w_hs, r_hs;
  logic               ram_we, ram_re;
  logic [MW-1:0]      widx;
  logic [NB-1:0][7:0] ram_q;
  logic               unused_user;

`ifdef NASTI_RAM_SLAVE_DECERR_EN
  function automatic logic oob(input logic [ADDR_WIDTH-1:0] a);
    return (64'(a) >> OFF) >= 64'(MEM_DEPTH);
  endfunction
`endif

  // Burst types with bit 1 set (WRAP and the reserved code) are not served: beats
  // still flow but writes are dropped and reads return zero.
  function automatic xact_t start(input logic [ID_WIDTH-1:0] id, input logic [ADDR_WIDTH-1:0] addr,
                                  input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    xact_t x;
    x.id    = id;
    x.addr  = addr;
    x.cnt   = len;
    x.size  = size;
    x.burst = burst;
    x.resp  = burst[1] ? SLVERR : OKAY;
`ifdef NASTI_RAM_SLAVE_DECERR_EN
    if (oob(addr)) x.resp = DECERR;
`endif
    x.drop  = (x.resp != OKAY);
    return x;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      prio  <= P_WRITE;
    end else begin
      state <= state_n;
      prio  <= prio_n;
    end
  end

  always_comb begin
    state_n  = state;
    prio_n   = prio;
    aw.ready = 1'b0;
    ar.ready = 1'b0;
    w.ready  = 1'b0;
    b.valid  = 1'b0;
    r.valid  = 1'b0;
    ram_re   = 1'b0;
    case (state)
      IDLE: if (rstn) begin
        aw.ready = aw.valid && (!ar.valid || prio == P_WRITE);
        ar.ready = ar.valid && (!aw.valid || prio == P_READ);
        if (aw.ready) begin
          state_n = WRITE;
          prio_n  = P_READ;
        end else if (ar.ready) begin
          state_n = RADDR;
          prio_n  = P_WRITE;
        end
      end
      WRITE: begin
        w.ready = 1'b1;
        if (w.valid && xq.cnt == 8'd0) state_n = WRESP;
      end
      WRESP: begin
        b.valid = 1'b1;
        if (b.ready) state_n = IDLE;
      end
      RADDR: begin
        ram_re  = !xq.drop;
        state_n = RDATA;
      end
      RDATA: begin
        r.valid = 1'b1;
        if (r.ready) state_n = (xq.cnt == 8'd0) ? IDLE : RADDR;
      end
      default: state_n = IDLE;
    endcase
  end

  assign aw_hs  = aw.valid & aw.ready;
  assign ar_hs  = ar.valid & ar.ready;
  assign w_hs   = w.valid & w.ready;
  assign r_hs   = r.valid & r.ready;
  assign ram_we = w_hs & ~xq.drop;
  assign widx   = MW'((64'(xq.addr) >> OFF) % 64'(MEM_DEPTH));

  // A misplaced w.last never shortens or stretches the burst; it only taints the response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xq <= '0;
    end else if (aw_hs) begin
      xq <= start(aw.id, aw.addr, aw.len, aw.size, aw.burst);
    end else if (ar_hs) begin
      xq <= start(ar.id, ar.addr, ar.len, ar.size, ar.burst);
    end else if (w_hs || r_hs) begin
      xq.cnt <= xq.cnt - 8'd1;
      if (xq.burst == INCR) xq.addr <= xq.addr + (ADDR_WIDTH'(1) << xq.size);
      if (w_hs && ((xq.cnt == 8'd0) != w.last) && xq.resp == OKAY) xq.resp <= SLVERR;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    nasti_ram_slave_lane #(.DEPTH(MEM_DEPTH), .AW(MW)) u_lane (
      .clk   (clk),
      .we    (ram_we & w.strb[i]),
      .re    (ram_re),
      .addr  (widx),
      .wdata (w.data[i*8 +: 8]),
      .rdata (ram_q[i])
    );
  end

  assign b.id   = (state == WRESP) ? xq.id : '0;
  assign b.resp = (state == WRESP) ? xq.resp : OKAY;
  assign b.user = '0;

  assign r.id   = (state == RDATA) ? xq.id : '0;
  assign r.data = (state == RDATA && !xq.drop) ? ram_q : '0;
  assign r.resp = (state == RDATA) ? xq.resp : OKAY;
  assign r.last = (state == RDATA) && (xq.cnt == 8'd0);
  assign r.user = '0;

  assign unused_user = ^{aw.user, ar.user, w.user};
endmodule

// File: tb/tb_nasti_ram_slave.sv
// Randomized bench for nasti_ram_slave against a byte-array/queue model of NASTI burst rules.
module tb_nasti_ram_slave;
  localparam int IDW = 1, AW = 16, DW = 64, UW = 1, DEPTH = 1024;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nasti_aw_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .USER_WIDTH(UW)) aw();
  nasti_w_if  #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) w();
  nasti_b_if  #(.ID_WIDTH(IDW), .USER_WIDTH(UW)) b();
  nasti_ar_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .USER_WIDTH(UW)) ar();
  nasti_r_if  #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) r();

  nasti_ram_slave #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .aw(aw), .w(w), .b(b), .ar(ar), .r(r)
  );

  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } bexp_t;
  typedef struct { logic [IDW-1:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rexp_t;

  logic [63:0] mdl [DEPTH];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  bexp_t exp_b[$];
  rexp_t exp_r[$];
  rexp_t rd_log[$];
  logic [1:0] last_bresp;
  int checks = 0, passes = 0;
  int rmode = 0;  // 0 random, 1 hold r.ready low, 2 hold it high

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: unexpected or missing event", name);
  endtask

  task automatic die(input string name);
    checks++;
    $display("FAIL %s: timed out", name);
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1, "aborting");
  endtask

  function automatic logic [1:0] start_resp(input logic [15:0] addr, input logic [1:0] burst);
    logic [1:0] rs;
    rs = (burst == 2'd2) ? 2'd2 : 2'd0;
`ifdef NASTI_RAM_SLAVE_DECERR_EN
    if ((int'(addr) >> 3) >= DEPTH) rs = 2'd3;
`endif
    return rs;
  endfunction

  // Compare process: every visible B/R beat is checked against the model queues.
  always @(negedge clk) begin
    rexp_t t;
    if (rstn) begin
      if (b.valid) begin
        if (exp_b.size() == 0) fail("b_unexpected");
        else begin
          chk("b_id", 64'(b.id), 64'(exp_b[0].id));
          chk("b_resp", 64'(b.resp), 64'(exp_b[0].resp));
          chk("b_user", 64'(b.user), 64'd0);
          if (b.ready) begin
            last_bresp = b.resp;
            void'(exp_b.pop_front());
          end
        end
      end
      if (r.valid) begin
        if (exp_r.size() == 0) fail("r_unexpected");
        else begin
          chk("r_id", 64'(r.id), 64'(exp_r[0].id));
          chk("r_data", r.data, exp_r[0].data);
          chk("r_resp", 64'(r.resp), 64'(exp_r[0].resp));
          chk("r_last", 64'(r.last), 64'(exp_r[0].last));
          chk("r_user", 64'(r.user), 64'd0);
          if (r.ready) begin
            t.id = r.id; t.data = r.data; t.resp = r.resp; t.last = r.last;
            rd_log.push_back(t);
            void'(exp_r.pop_front());
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    b.ready = ($urandom_range(3) != 0);
    r.ready = (rmode == 2) ? 1'b1 : (rmode == 1) ? 1'b0 : ($urandom_range(3) != 0);
  end

  task automatic do_write(input logic [IDW-1:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int bad_last, input bit gaps);
    logic [15:0] a;
    logic [1:0] rs;
    bit drop, lst;
    int n, idx;
    a = addr;
    rs = start_resp(addr, burst);
    drop = (rs != 2'd0);
    for (int i = 0; i <= int'(len); i++) begin
      lst = (i == int'(len)) ^ (i == bad_last);
      if (lst != (i == int'(len)) && rs == 2'd0) rs = 2'd2;
      idx = (int'(a) >> 3) % DEPTH;
      if (!drop) for (int k = 0; k < 8; k++) if (ws[i][k]) mdl[idx][k*8 +: 8] = wd[i][k*8 +: 8];
      if (burst == 2'd1) a = a + (16'd1 << size);
    end
    exp_b.push_back('{id: id, resp: rs});
    @(posedge clk); #1;
    aw.id = id; aw.addr = addr; aw.len = len; aw.size = size; aw.burst = burst; aw.valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!aw.ready && n < 200);
    if (!aw.ready) die("aw_grant");
    @(posedge clk); #1;
    aw.valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps) repeat ($urandom_range(1)) begin w.valid = 1'b0; @(posedge clk); #1; end
      w.data = wd[i]; w.strb = ws[i]; w.last = (i == int'(len)) ^ (i == bad_last); w.valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!w.ready && n < 200);
      if (!w.ready) die("w_ready");
      @(posedge clk); #1;
    end
    w.valid = 1'b0;
    @(negedge clk);
    chk("b_latency", 64'(b.valid), 64'd1);
    n = 0;
    while (exp_b.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    if (exp_b.size() != 0) die("b_done");
  endtask

  task automatic rd_expect(input logic [IDW-1:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    logic [15:0] a;
    logic [1:0] rs;
    rexp_t e;
    a = addr;
    rs = start_resp(addr, burst);
    for (int i = 0; i <= int'(len); i++) begin
      e.id = id;
      e.data = (rs != 2'd0) ? 64'd0 : mdl[(int'(a) >> 3) % DEPTH];
      e.resp = rs;
      e.last = (i == int'(len));
      exp_r.push_back(e);
      if (burst == 2'd1) a = a + (16'd1 << size);
    end
  endtask

  task automatic send_ar(input logic [IDW-1:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    @(posedge clk); #1;
    ar.id = id; ar.addr = addr; ar.len = len; ar.size = size; ar.burst = burst; ar.valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ar.ready && n < 200);
    if (!ar.ready) die("ar_grant");
    @(posedge clk); #1;
    ar.valid = 1'b0;
  endtask

  task automatic do_read(input logic [IDW-1:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    rd_log.delete();
    rd_expect(id, addr, len, size, burst);
    send_ar(id, addr, len, size, burst);
    @(negedge clk);
    chk("r_latency_1", 64'(r.valid), 64'd0);
    @(negedge clk);
    chk("r_latency_2", 64'(r.valid), 64'd1);
    n = 0;
    while (exp_r.size() != 0 && n < 4000) begin @(negedge clk); n++; end
    if (exp_r.size() != 0) die("r_done");
  endtask

  initial begin
    int n;
    logic [15:0] a;
    logic [7:0] ln;
    aw.valid = 1'b1; ar.valid = 1'b1; w.valid = 1'b1;
    aw.id = '0; aw.addr = '0; aw.len = '0; aw.size = '0; aw.burst = '0; aw.user = '0;
    ar.id = '0; ar.addr = '0; ar.len = '0; ar.size = '0; ar.burst = '0; ar.user = '0;
    w.data = '0; w.strb = '0; w.last = 1'b0; w.user = '0;
    b.ready = 1'b0; r.ready = 1'b0;

    #12;
    chk("rst_aw_ready", 64'(aw.ready), 64'd0);
    chk("rst_ar_ready", 64'(ar.ready), 64'd0);
    chk("rst_w_ready", 64'(w.ready), 64'd0);
    chk("rst_b_valid", 64'(b.valid), 64'd0);
    chk("rst_r_valid", 64'(r.valid), 64'd0);
    chk("rst_r_last", 64'(r.last), 64'd0);
    chk("rst_r_data", r.data, 64'd0);
    chk("rst_b_resp", 64'(b.resp), 64'd0);
    chk("rst_r_id", 64'(r.id), 64'd0);
    aw.valid = 1'b0; ar.valid = 1'b0; w.valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;

    // Fill the RAM so every later read has a defined model value.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      do_write(IDW'(blk), 16'(blk * 2048), 8'd255, 3'd3, 2'd1, -1, 1'b0);
    end

    // RAM survives reset; after reset a simultaneous AW/AR goes to the write.
    @(negedge clk); rstn = 1'b0;
    repeat (2) @(posedge clk); #1; rstn = 1'b1;
    wd[0] = 64'hCAFE_F00D_0000_0001; ws[0] = 8'hFF;
    fork
      do_write(1'b0, 16'h0100, 8'd0, 3'd3, 2'd1, -1, 1'b0);
      do_read(1'b1, 16'h0200, 8'd0, 3'd3, 2'd1);
      begin
        @(posedge clk); @(negedge clk);
        chk("arb_aw_ready", 64'(aw.ready), 64'd1);
        chk("arb_ar_ready", 64'(ar.ready), 64'd0);
      end
    join

    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    do_write(1'b1, 16'h0010, 8'd0, 3'd3, 2'd1, -1, 1'b0);
    chk("single_bresp", 64'(last_bresp), 64'd0);
    chk("model_single", mdl[2], 64'h1122334455667788);
    do_read(1'b1, 16'h0010, 8'd0, 3'd3, 2'd1);
    chk("single_rd_n", 64'(rd_log.size()), 64'd1);
    if (rd_log.size() > 0) begin
      chk("single_rdata", rd_log[0].data, 64'h1122334455667788);
      chk("single_rlast", 64'(rd_log[0].last), 64'd1);
    end

    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i); ws[i] = 8'hFF; end
    do_write(1'b0, 16'h0040, 8'd3, 3'd3, 2'd1, -1, 1'b1);
    do_read(1'b0, 16'h0040, 8'd3, 3'd3, 2'd1);
    chk("incr_rd_n", 64'(rd_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
      chk("incr_rdata", rd_log[i].data, 64'(i));
      chk("incr_rlast", 64'(rd_log[i].last), 64'(i == 3));
    end

    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    do_write(1'b0, 16'h0080, 8'd0, 3'd3, 2'd1, -1, 1'b0);
    wd[0] = 64'd0; ws[0] = 8'h0F;
    do_write(1'b0, 16'h0080, 8'd0, 3'd3, 2'd1, -1, 1'b0);
    do_read(1'b0, 16'h0080, 8'd0, 3'd3, 2'd1);
    if (rd_log.size() > 0) chk("strobe_rdata", rd_log[0].data, 64'hFFFF_FFFF_0000_0000);
    else fail("strobe_rd_n");

    rmode = 1;
    fork
      do_read(1'b1, 16'h0048, 8'd1, 3'd3, 2'd1);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!r.valid && n < 50);
        repeat (5) begin
          chk("bp_valid", 64'(r.valid), 64'd1);
          chk("bp_data", r.data, 64'd1);
          chk("bp_last", 64'(r.last), 64'd0);
          @(negedge clk);
        end
        rmode = 0;
      end
    join

    do_read(1'b0, 16'h0040, 8'd1, 3'd3, 2'd2);
    chk("wrap_rd_n", 64'(rd_log.size()), 64'd2);
    for (int i = 0; i < rd_log.size(); i++) begin
      chk("wrap_rdata", rd_log[i].data, 64'd0);
      chk("wrap_rresp", 64'(rd_log[i].resp), 64'd2);
    end
    wd[0] = 64'hDEAD; wd[1] = 64'hBEEF; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(1'b0, 16'h0040, 8'd1, 3'd3, 2'd2, -1, 1'b0);
    chk("wrap_bresp", 64'(last_bresp), 64'd2);

    do_write(1'b1, 16'h0300, 8'd1, 3'd3, 2'd1, 0, 1'b0);
    chk("early_last_bresp", 64'(last_bresp), 64'd2);

    wd[0] = 64'h0BAD_0BAD_0BAD_0BAD; ws[0] = 8'hFF;
    do_write(1'b0, 16'(DEPTH * 8), 8'd0, 3'd3, 2'd1, -1, 1'b0);
    do_read(1'b0, 16'(DEPTH * 8), 8'd0, 3'd3, 2'd1);
`ifdef NASTI_RAM_SLAVE_DECERR_EN
    chk("oob_bresp", 64'(last_bresp), 64'd3);
    if (rd_log.size() > 0) chk("oob_rresp", 64'(rd_log[0].resp), 64'd3);
`else
    chk("alias_bresp", 64'(last_bresp), 64'd0);
    if (rd_log.size() > 0) chk("alias_rdata", rd_log[0].data, 64'h0BAD_0BAD_0BAD_0BAD);
`endif

    repeat (60) begin
      a = 16'($urandom);
      ln = 8'($urandom_range(7));
      if ($urandom_range(1) == 1) begin
        for (int i = 0; i <= int'(ln); i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
        do_write(IDW'($urandom), a, ln, 3'($urandom_range(3)),
                 ($urandom_range(9) == 0) ? 2'd2 : 2'($urandom_range(1)),
                 ($urandom_range(7) == 0) ? int'($urandom_range(int'(ln))) : -1, 1'b1);
      end else begin
        do_read(IDW'($urandom), a, ln, 3'($urandom_range(3)),
                ($urandom_range(9) == 0) ? 2'd2 : 2'($urandom_range(1)));
      end
    end

    // Reset while beat 1 of a 4-beat read is on the bus.
    rmode = 2;
    rd_log.delete();
    rd_expect(1'b1, 16'h0040, 8'd3, 3'd3, 2'd1);
    send_ar(1'b1, 16'h0040, 8'd3, 3'd3, 2'd1);
    n = 0;
    while (rd_log.size() < 1 && n < 50) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!r.valid && n < 50);
    if (!r.valid) die("midrst_beat1");
    #2 rstn = 1'b0;
    #1;
    chk("midrst_r_valid", 64'(r.valid), 64'd0);
    chk("midrst_b_valid", 64'(b.valid), 64'd0);
    chk("midrst_aw_ready", 64'(aw.ready), 64'd0);
    chk("midrst_ar_ready", 64'(ar.ready), 64'd0);
    chk("midrst_w_ready", 64'(w.ready), 64'd0);
    chk("midrst_r_data", r.data, 64'd0);
    chk("midrst_r_last", 64'(r.last), 64'd0);
    exp_r.delete();
    repeat (2) @(posedge clk); #1;
    rstn = 1'b1;
    rmode = 0;
    do_read(1'b1, 16'h0040, 8'd3, 3'd3, 2'd1);
    chk("postrst_rd_n", 64'(rd_log.size()), 64'd4);
    if (rd_log.size() == 4) chk("postrst_rdata3", rd_log[3].data, 64'd3);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
